nibble_serial_adder_ctrl: RTL and testbench

Multi-cycle sequencer that adds or subtracts two WIDTH-bit operands by streaming them, one 4-bit nibble per cycle, through the team's existing 4-bit ripple-carry adder stage. The block sits directly upstream and downstream of that adder:
- It drives the adder's a/b/cin inputs.
- It consumes the adder's sum/cout on the same cycle.
- It registers the nibble carry between cycles and assembles the full-width result.

Operands enter and results leave on valid/ready handshakes.

---
 rtl/nibble_serial_adder_ctrl_if.sv | 36 +++
 rtl/nibble_serial_adder_ctrl.sv | 126 ++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand, result and 4-bit adder-stage signals of the nibble-serial add/sub sequencer.
interface nibble_serial_adder_ctrl_if #(
   parameter int NIBBLES = 4
);
   localparam int WIDTH = 4 * NIBBLES;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_sub;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             out_ovf;

   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;

   // Environment side: operand source, result sink and the external adder stage.
   modport master (
      output in_valid, in_a, in_b, in_cin, in_sub, out_ready, add_sum, add_cout,
      input  in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_sub, out_ready, add_sum, add_cout,
      output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Streams two WIDTH-bit operands nibble by nibble through an external 4-bit adder; out_valid rises NIBBLES+1 edges after accept.
// in_ready only in IDLE; the result is held in DONE until out_ready, so upstream and downstream stall independently.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   nibble_serial_adder_ctrl_if.slave bus
);
   localparam int WIDTH = 4 * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic [3:0]       nib_a, nib_b;

   always_comb begin : nibble_select
      nib_a = '0;
      nib_b = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            nib_a = a_q[4*k +: 4];
            nib_b = b_q[4*k +: 4];
         end
      end
   end

   // Adder drive kept apart from the add_sum consumer so the path through the external adder stays acyclic.
   always_comb begin : adder_drive
      bus.add_a   = '0;
      bus.add_b   = '0;
      bus.add_cin = 1'b0;
      if (state_q == RUN) begin
         bus.add_a   = nib_a;
         bus.add_b   = nib_b;
         bus.add_cin = carry_q;
      end
   end

   always_comb begin : next_state
      state_d       = state_q;
      idx_d         = idx_q;
      a_d           = a_q;
      b_d           = b_q;
      sum_d         = sum_q;
      carry_d       = carry_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_sum   = '0;
      bus.out_cout  = 1'b0;
      bus.out_ovf   = 1'b0;

      unique case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               a_d     = bus.in_a;
               // Subtract is A + ~B + 1, so B is stored inverted and the +1 rides in as carry-in.
               b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
               carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NIBBLES; k++) begin
               if (idx_q == IDX_W'(k)) begin
                  sum_d[4*k +: 4] = bus.add_sum;
               end
            end
            carry_d = bus.add_cout;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            bus.out_sum   = sum_q;
            bus.out_cout  = carry_q;
            bus.out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
      end
   end

   result_held_under_backpressure: assert property (
      @(posedge clk) disable iff (!rst_n)
      bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_sum)
   );

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Bench for nibble_serial_adder_ctrl: plays the external 4-bit adder and checks every cycle against an arithmetic model.
module tb_nibble_serial_adder_ctrl;
   localparam int NB = 4;
   localparam int W  = 4 * NB;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   bit   rand_rdy = 1'b0;
   int   sends = 0;

   // Model state owned by the compare process
   int          run_k   = -1;
   bit          res_pend = 1'b0;
   logic [W-1:0] ca, cb, es;
   logic         ccin, csub, ec, eo;
   int          n_acc = 0, n_done = 0, n_abort = 0;

   logic [8:0] eb0 [NB] = '{9'h04D, 9'h13C, 9'h12F, 9'h110};
   logic [8:0] eb_none [NB] = '{default: 9'h000};

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl_if #(.NIBBLES(NB)) bus ();

   nibble_serial_adder_ctrl #(.NIBBLES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // The external 4-bit ripple-carry stage
   always_comb {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: got no DUT event within budget, expected one at %0t", name, $time);
   endtask

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                                 input logic sub, output logic [W-1:0] s, output logic co,
                                 output logic ov);
      longint ua, ub, sa, sb, r, sr, lim;
      lim = longint'(1) << W;
      ua  = longint'(a);
      ub  = longint'(b);
      sa  = a[W-1] ? ua - lim : ua;
      sb  = b[W-1] ? ub - lim : ub;
      if (sub) begin
         r  = ua - ub;
         co = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = ua + ub + longint'(cin);
         co = (r >= lim);
         sr = sa + sb + longint'(cin);
      end
      s  = r[W-1:0];
      ov = (sr >= lim / 2) || (sr < -(lim / 2));
   endfunction

   // {carry into nibble k, nibble k of A, nibble k of the (possibly inverted) B}
   function automatic logic [8:0] bus_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub, input int k);
      logic [W-1:0] bp;
      longint ua, ub, m, c0, ck, an, bn;
      bp = sub ? ~b : b;
      ua = longint'(a);
      ub = longint'(bp);
      m  = (longint'(1) << (4 * k)) - 1;
      c0 = sub ? 1 : longint'(cin);
      ck = ((ua & m) + (ub & m) + c0) >> (4 * k);
      an = (ua >> (4 * k)) & 15;
      bn = (ub >> (4 * k)) & 15;
      return {ck[0], an[3:0], bn[3:0]};
   endfunction

   initial begin : compare
      bit busy, out_hs, acc;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            if (run_k >= 0 || res_pend) n_abort++;
            run_k    = -1;
            res_pend = 1'b0;
            chk("rst_in_ready", bus.in_ready, 1);
            chk("rst_outputs", {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf,
                                bus.add_a, bus.add_b, bus.add_cin}, 0);
         end else begin
            busy   = (run_k >= 0) || res_pend;
            out_hs = res_pend && bus.out_ready;
            acc    = !busy && bus.in_valid;
            chk("in_ready", bus.in_ready, !busy);
            chk("out_valid", bus.out_valid, res_pend);
            if (res_pend) begin
               chk("out_sum", bus.out_sum, es);
               chk("out_cout", bus.out_cout, ec);
               chk("out_ovf", bus.out_ovf, eo);
            end
            if (run_k >= 0) begin
               chk("add_bus", {bus.add_cin, bus.add_a, bus.add_b}, bus_exp(ca, cb, ccin, csub, run_k));
               run_k++;
               if (run_k == NB) begin
                  run_k    = -1;
                  res_pend = 1'b1;
               end
            end else begin
               chk("add_bus_idle", {bus.add_cin, bus.add_a, bus.add_b}, 0);
            end
            if (out_hs) begin
               res_pend = 1'b0;
               n_done++;
            end
            if (acc) begin
               ca   = bus.in_a;
               cb   = bus.in_b;
               ccin = bus.in_cin;
               csub = bus.in_sub;
               model(ca, cb, ccin, csub, es, ec, eo);
               run_k = 0;
               n_acc++;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_cin   = cin;
      bus.in_sub   = sub;
      for (int i = 0; i <= 64; i++) begin
         if (i == 64) begin
            timeout("send_accept");
            bus.in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         if (bus.in_ready && rst_n) break;
         tick();
      end
      tick();
      bus.in_valid = 1'b0;
      sends++;
   endtask

   task automatic wait_result(inout int lat);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) return;
      end
      timeout("wait_out_valid");
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input logic [W-1:0] xs,
                           input logic xc, input logic xo, input bit chk_bus,
                           input logic [8:0] eb [NB]);
      logic [W-1:0] ms;
      logic         mc, mo;
      int           lat;
      model(a, b, cin, sub, ms, mc, mo);
      chk({name, "_model"}, {ms, mc, mo}, {xs, xc, xo});
      send(a, b, cin, sub);
      lat = 0;
      if (chk_bus) begin
         for (int k = 0; k < NB; k++) begin
            @(negedge clk);
            lat++;
            chk({name, "_bus"}, {bus.add_cin, bus.add_a, bus.add_b}, eb[k]);
         end
      end
      wait_result(lat);
      chk({name, "_latency"}, lat, NB + 1);
      chk({name, "_sum"}, bus.out_sum, xs);
      chk({name, "_cout"}, bus.out_cout, xc);
      chk({name, "_ovf"}, bus.out_ovf, xo);
      tick();
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(16'h8000);
         3:       return W'(16'h7FFF);
         default: return W'($urandom);
      endcase
   endfunction

   initial begin : main
      int lat;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_cin    = 1'b0;
      bus.in_sub    = 1'b0;
      bus.out_ready = 1'b1;
      #22 rst_n = 1'b1;
      tick();

      directed("add_1234_0fcd", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b1, eb0);
      directed("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, eb_none);
      directed("add_ffff_cin",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, eb_none);
      directed("sub_5_7",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, eb_none);
      directed("sub_8000_1",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, eb_none);
      directed("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, eb_none);

      // Result held in DONE while a second operand waits upstream
      bus.out_ready = 1'b0;
      send(16'h0102, 16'h0304, 1'b0, 1'b0);
      lat = 0;
      wait_result(lat);
      tick();
      bus.in_valid = 1'b1;
      bus.in_a     = 16'h1111;
      bus.in_b     = 16'h0001;
      bus.in_cin   = 1'b1;
      bus.in_sub   = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_out_sum", bus.out_sum, 16'h0406);
         chk("bp_in_ready", bus.in_ready, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", bus.out_valid, 1);
      tick();
      @(negedge clk);
      chk("bp_idle_in_ready", bus.in_ready, 1);
      chk("bp_idle_out_valid", bus.out_valid, 0);
      tick();
      bus.in_valid = 1'b0;
      sends++;
      lat = 0;
      wait_result(lat);
      chk("bp_pending_latency", lat, NB + 1);
      chk("bp_pending_sum", bus.out_sum, 16'h1110);
      chk("bp_pending_cout", bus.out_cout, 1);
      tick();

      // Asynchronous reset while nibble 2 is on the adder bus
      send(16'h1111, 16'h2222, 1'b0, 1'b0);
      tick();
      tick();
      chk("pre_reset_nibble2_a", bus.add_a, 4'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_in_ready", bus.in_ready, 1);
      chk("async_rst_outputs", {bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf,
                                bus.add_a, bus.add_b, bus.add_cin}, 0);
      @(negedge clk);
      @(negedge clk);
      tick();
      #2 rst_n = 1'b1;
      directed("post_reset_1_1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, eb_none);

      // Randomized traffic with random backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 150; n++) begin
         send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) tick();
      end
      rand_rdy      = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3 * NB) tick();
      @(negedge clk);
      chk("drain_in_ready", bus.in_ready, 1);
      chk("txn_balance", n_done + n_abort, n_acc);
      chk("txn_count", n_acc, sends);
      chk("abort_count", n_abort, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
